// File: rtl/snake_reader.sv
// snake_reader: scans a 16x16 board row-major through a 1-cycle-latency memory,
// counting snake cells, capturing the cell code under the snake head and,
// when SNAKE_READER_FOOD_EN is defined, the location of the first food cell.
module snake_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] head_x,
    input  logic [3:0] head_y,
    input  logic [1:0] data_in,
    output logic       readSnake,
    output logic [3:0] x_loc,
    output logic [3:0] y_loc,
    output logic       busy,
    output logic       done,
    output logic [8:0] snake_count,
    output logic [1:0] head_code,
    output logic       food_found,
    output logic [3:0] food_x,
    output logic [3:0] food_y
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t     r_state;
    logic [3:0] r_hx, r_hy, r_dx, r_dy;
    logic       r_cap;
    logic       w_accept;
    logic       w_food;
    assign w_accept = (r_state == IDLE) && start;
    assign w_food   = r_cap && (data_in == 2'b01);
    // Scan FSM: address generation, delayed address copy for the read latency, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            readSnake   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            x_loc       <= 4'd0;
            y_loc       <= 4'd0;
            snake_count <= 9'd0;
            head_code   <= 2'b00;
            r_hx        <= 4'd0;
            r_hy        <= 4'd0;
            r_dx        <= 4'd0;
            r_dy        <= 4'd0;
            r_cap       <= 1'b0;
        end else begin
            done  <= 1'b0;
            r_cap <= (r_state == SCAN);
            r_dx  <= x_loc;
            r_dy  <= y_loc;
            if (r_cap) begin
                if (data_in == 2'b10) snake_count <= snake_count + 9'd1;
                if (r_dx == r_hx && r_dy == r_hy) head_code <= data_in;
            end
            case (r_state)
                IDLE: if (start) begin
                    r_state     <= SCAN;
                    x_loc       <= 4'd0;
                    y_loc       <= 4'd0;
                    readSnake   <= 1'b1;
                    busy        <= 1'b1;
                    snake_count <= 9'd0;
                    head_code   <= 2'b00;
                    r_hx        <= head_x;
                    r_hy        <= head_y;
                end
                SCAN: if (x_loc == 4'd15 && y_loc == 4'd15) begin
                    r_state   <= DRAIN;
                    readSnake <= 1'b0;
                end else begin
                    x_loc <= x_loc + 4'd1;
                    if (x_loc == 4'd15) y_loc <= y_loc + 4'd1;
                end
                DRAIN: r_state <= DONE;
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef SNAKE_READER_FOOD_EN
    // First food cell in scan order is latched; later food cells are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            food_found <= 1'b0;
            food_x     <= 4'd0;
            food_y     <= 4'd0;
        end else if (w_accept) begin
            food_found <= 1'b0;
            food_x     <= 4'd0;
            food_y     <= 4'd0;
        end else if (w_food && !food_found) begin
            food_found <= 1'b1;
            food_x     <= r_dx;
            food_y     <= r_dy;
        end
    end
`else
    logic w_unused;
    assign w_unused   = w_accept ^ w_food;
    assign food_found = 1'b0;
    assign food_x     = 4'd0;
    assign food_y     = 4'd0;
`endif
endmodule
